// File: rtl/rv32_imem_ctrl.sv
// rv32_imem_ctrl: async-read instruction memory with a DMA program loader that stalls the core while it writes.
module rv32_imem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_addr,
  output logic [31:0]     instr,
  output logic            fetch_fault,
  output logic            stall,
  input  logic            dma_start,
  input  logic [XLEN-1:0] dma_base,
  input  logic [15:0]     dma_len,
  input  logic            dma_valid,
  input  logic [31:0]     dma_data,
  output logic            dma_ready,
  output logic            dma_done,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t        state, state_d;
  logic [AW-1:0] wptr, wptr_d;
  logic [15:0]   rem, rem_d;
  logic          we;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          unused_base;
  assign unused_base = ^{dma_base[XLEN-1:AW+2], dma_base[1:0]};
  always_comb begin
    state_d = state;
    wptr_d  = wptr;
    rem_d   = rem;
    we      = 1'b0;
    case (state)
      IDLE: if (dma_start) begin
        wptr_d  = dma_base[AW+1:2];
        rem_d   = dma_len;
        state_d = (dma_len != 16'd0) ? LOAD : DONE;
      end
      LOAD: if (dma_valid) begin
        we      = 1'b1;
        wptr_d  = wptr + AW'(1);
        rem_d   = rem - 16'd1;
        state_d = (rem == 16'd1) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr  <= '0;
      rem   <= '0;
    end else begin
      state <= state_d;
      wptr  <= wptr_d;
      rem   <= rem_d;
    end
  end
  // Array is never reset; a reset edge also suppresses any pending beat.
  always_ff @(posedge clk) begin
    if (!rst && we) mem[wptr] <= dma_data;
  end
  assign stall       = state != IDLE;
  assign busy        = state != IDLE;
  assign dma_ready   = state == LOAD;
  assign dma_done    = state == DONE;
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) | (|fetch_addr[XLEN-1:AW+2]);
  assign instr       = (stall | fetch_fault) ? NOP_INSTR : mem[fetch_addr[AW+1:2]];
endmodule

// File: doc/rv32_imem_ctrl.md
# rv32_imem_ctrl

Instruction-memory controller for the RV32IM single-cycle core. It answers the PC's fetch address with the instruction word in the same cycle, through an asynchronous-read word array. It also accepts a DMA load stream that writes program words into that array. While a load is in progress it drives the core `stall` input, which freezes the PC, and returns NOPs to the datapath.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit instruction words; power of two; `AW = $clog2(DEPTH_WORDS)`.
- `NOP_INSTR`, 32'h0000_0013: word returned on fault or stall (`addi x0,x0,0`).
- `clk`  in  1  core clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_addr`  in  XLEN  byte address from the PC.
- `instr`  out  32  instruction word for `fetch_addr`.
- `fetch_fault`  out  1  fetch address is misaligned or out of range.
- `stall`  out  1  hold the PC; high while a DMA load owns the array.
- `dma_start`  in  1  one-cycle request to begin a load.
- `dma_base`  in  XLEN  byte start address; sampled with `dma_start`; bits [1:0] ignored.
- `dma_len`  in  16  word count; sampled with `dma_start`.
- `dma_valid`  in  1  stream word valid.
- `dma_data`  in  32  stream word.
- `dma_ready`  out  1  controller accepts the stream word this cycle.
- `dma_done`  out  1  one-cycle pulse when the load completes.
- `busy`  out  1  FSM is not IDLE.

## Operation
- FSM states are IDLE, LOAD and DONE. `state`, the word pointer `wptr[AW-1:0]` and the remaining count `rem[15:0]` are registers.
- IDLE:
  - If `dma_start`=1: latch `wptr <= dma_base[AW+1:2]` and `rem <= dma_len`.
  - Go to LOAD if `dma_len`≠0, otherwise go straight to DONE.
- LOAD:
  - `dma_ready`=1.
  - On `dma_valid & dma_ready`: write `mem[wptr] <= dma_data`, then `wptr <= wptr+1` (wraps modulo `DEPTH_WORDS`) and `rem <= rem-1`.
  - The beat with `rem`=1 moves the FSM to DONE.
  - `dma_valid`=0 inserts wait cycles with no limit; nothing advances.
- DONE: `dma_done`=1 for exactly one cycle, then back to IDLE.
- Outputs decoded from state: `stall = busy = (state != IDLE)`, `dma_ready = (state == LOAD)`.
- `dma_start` outside IDLE is ignored. No queuing. `dma_base`/`dma_len` are not re-sampled.
- Fetch path (combinational):
  - `fetch_fault = (fetch_addr[1:0] != 0) | (fetch_addr >= DEPTH_WORDS*4)`.
  - `instr = (stall | fetch_fault) ? NOP_INSTR : mem[fetch_addr[AW+1:2]]`.
- A fault does not change state. Trap handling is the core's job.
- `dma_base` beyond the array wraps via `wptr` truncation. It is not an error.
- Array contents are not reset. `rst` never clears `mem`.

## Timing
- Reset values: `state`=IDLE, `wptr`=0, `rem`=0, `stall`=0, `busy`=0, `dma_ready`=0, `dma_done`=0.
- `fetch_fault` and `instr` are combinational from `fetch_addr` and the array at all times, including during reset.
- Fetch latency is 0 cycles. The read is asynchronous, so the word is valid in the same cycle as `fetch_addr`.
- Stall timing around a start:
  - The cycle carrying `dma_start` still fetches normally (`stall`=0), so the PC advances on that edge.
  - `stall` rises on the following cycle.
- Write visibility: a word written on edge N is readable by fetch from cycle N+1. There is no same-cycle bypass, because `stall` masks fetch during LOAD anyway.
- An N-word load with no wait states keeps `stall` high for N+1 cycles: N LOAD cycles plus 1 DONE cycle.
- `dma_len`=0 keeps `stall` high for 1 cycle (DONE only) and still pulses `dma_done`.
- `stall` falls in the cycle after DONE. The first post-load fetch sees the new contents.
- Reset mid-LOAD: on the next edge go to IDLE with `stall`=0. No `dma_done` pulse. Words already written remain in the array.
- `dma_start` and `rst` asserted in the same cycle: reset wins and the start is dropped.

## Test plan
- Reset, then `fetch_addr`=0x0 -> `stall`=0, `fetch_fault`=0, `instr`=mem[0]. The value is uninitialised; the bench preloads it via backdoor.
- `dma_start` with base 0x0, len 4, words 0xA0..0xA3, `dma_valid` held high -> `stall`=1 for 5 cycles, `dma_done` pulses in cycle 5. Fetches of 0x0/0x4/0x8/0xC then return 0xA0..0xA3, and `instr`=0x13 throughout the stall.
- Load with base `(DEPTH_WORDS-2)*4`, len 4 -> writes land at words 1022, 1023, 0, 1. The pointer wraps and no fault is raised.
- `fetch_addr`=0x2 -> `fetch_fault`=1, `instr`=0x13. `fetch_addr`=DEPTH_WORDS*4 -> `fetch_fault`=1. `fetch_addr`=DEPTH_WORDS*4-4 -> `fetch_fault`=0.
- `dma_valid` toggling 1,0,0,1 during a len-2 load; a second `dma_start` in LOAD -> exactly 2 writes, the second start is ignored, and `busy` drops after one DONE cycle.
- `rst` after 2 of 5 beats -> next cycle `stall`=0, no `dma_done`. Words 0..1 hold the new data and words 2..4 keep their old contents.
